// File: rtl/axi_monitor_pkg.sv
// Shared definitions for the AXI4 protocol monitor: violation codes, widths,
// burst encodings and the priority helper that picks the reported code.
package axi_monitor_pkg;

  localparam int ERR_CODE_W  = 4;
  localparam int ERR_FLAGS_W = 16;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [ERR_CODE_W-1:0] {
    ERR_NONE           = 4'd0,
    ERR_AW_UNSTABLE    = 4'd1,
    ERR_W_UNSTABLE     = 4'd2,
    ERR_AR_UNSTABLE    = 4'd3,
    ERR_WLAST_EARLY    = 4'd4,
    ERR_WLAST_MISSING  = 4'd5,
    ERR_B_UNEXPECTED   = 4'd6,
    ERR_RLAST_EARLY    = 4'd7,
    ERR_RLAST_MISSING  = 4'd8,
    ERR_RID_MISMATCH   = 4'd9,
    ERR_R_UNEXPECTED   = 4'd10,
    ERR_TRACK_OVERFLOW = 4'd11,
    ERR_STALL_TIMEOUT  = 4'd12,
    ERR_W_NO_AW        = 4'd13
  } axi_mon_err_e;

  // Lowest set violation bit wins; bit 0 is never a real code.
  function automatic logic [ERR_CODE_W-1:0] first_err(input logic [ERR_FLAGS_W-1:0] v);
    logic [ERR_CODE_W-1:0] code;
    code = 4'd0;
    for (int i = ERR_FLAGS_W - 1; i >= 1; i--) begin
      if (v[i]) code = ERR_CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/axi_monitor_track_fifo.sv
// Small synchronous FIFO tracking accepted addresses; push while full is
// accepted only when a pop happens in the same cycle.
module axi_monitor_track_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == (PTR_W+1)'(0));
  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi_protocol_monitor.sv
// Passive AXI4 link monitor: burst tracking, LAST/ID checks, handshake
// stability and stall timeouts, reported through registered error outputs.
module axi_protocol_monitor
  import axi_monitor_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_ID_WIDTH     = 8,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int STALL_LIMIT      = 256,
  parameter int LOG_ENABLE       = 1,
  parameter int DEBUG_LOG_ENABLE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  input  logic [1:0]                  axi_aw_burst,
  input  logic [2:0]                  axi_aw_size,
  input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
  input  logic [7:0]                  axi_aw_len,
  input  logic                        axi_aw_valid,
  input  logic                        axi_aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
  input  logic                        axi_w_last,
  input  logic                        axi_w_valid,
  input  logic                        axi_w_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_b_id,
  input  logic [1:0]                  axi_b_resp,
  input  logic                        axi_b_valid,
  input  logic                        axi_b_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
  input  logic [1:0]                  axi_ar_burst,
  input  logic [2:0]                  axi_ar_size,
  input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
  input  logic [7:0]                  axi_ar_len,
  input  logic                        axi_ar_valid,
  input  logic                        axi_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
  input  logic [1:0]                  axi_r_resp,
  input  logic                        axi_r_last,
  input  logic                        axi_r_valid,
  input  logic                        axi_r_ready,
  output logic                        err_valid,
  output logic [ERR_CODE_W-1:0]       err_code,
  output logic [ERR_FLAGS_W-1:0]      err_flags,
  output logic [31:0]                 wr_burst_cnt,
  output logic [31:0]                 rd_burst_cnt,
  output logic [31:0]                 stall_cnt,
  output logic                        busy
);

  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int A_PAY_W   = AXI_ADDR_WIDTH + 2 + 3 + AXI_ID_WIDTH + 8;
  localparam int W_PAY_W   = AXI_DATA_WIDTH + AXI_STRB_WIDTH + 1;
  localparam int AR_FIFO_W = AXI_ID_WIDTH + 8;
  localparam int TMR_W     = $clog2(STALL_LIMIT + 1);
  localparam int NCH       = 5;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic [NCH-1:0] stalled_s;
  logic [A_PAY_W-1:0] aw_pay_s, ar_pay_s, aw_pay_r, ar_pay_r;
  logic [W_PAY_W-1:0] w_pay_s, w_pay_r;
  logic aw_stall_r, w_stall_r, ar_stall_r;

  logic [7:0] aw_dout_s, aw_head_len_s, wbeat_r;
  logic aw_full_s, aw_empty_s, aw_head_valid_s, aw_push_s, aw_pop_s, w_done_s;
  logic [AR_FIFO_W-1:0] ar_dout_s;
  logic [AXI_ID_WIDTH-1:0] ar_head_id_s;
  logic [7:0] ar_head_len_s, rbeat_r;
  logic ar_full_s, ar_empty_s, ar_head_valid_s, ar_push_s, ar_pop_s, r_done_s;
  logic [15:0] b_pending_r;
  logic b_dec_s;

  logic [TMR_W-1:0] tmr_r [NCH];
  logic timeout_s;
  logic [ERR_FLAGS_W-1:0] viol_s;

  logic err_valid_r;
  logic [ERR_CODE_W-1:0] err_code_r;
  logic [ERR_FLAGS_W-1:0] err_flags_r;
  logic [31:0] wr_cnt_r, rd_cnt_r, stall_cnt_r;

  assign aw_hs_s = axi_aw_valid && axi_aw_ready;
  assign w_hs_s  = axi_w_valid && axi_w_ready;
  assign b_hs_s  = axi_b_valid && axi_b_ready;
  assign ar_hs_s = axi_ar_valid && axi_ar_ready;
  assign r_hs_s  = axi_r_valid && axi_r_ready;
  assign stalled_s = {axi_r_valid && !axi_r_ready, axi_ar_valid && !axi_ar_ready,
                      axi_b_valid && !axi_b_ready, axi_w_valid && !axi_w_ready,
                      axi_aw_valid && !axi_aw_ready};

  assign aw_pay_s = {axi_aw_addr, axi_aw_burst, axi_aw_size, axi_aw_id, axi_aw_len};
  assign ar_pay_s = {axi_ar_addr, axi_ar_burst, axi_ar_size, axi_ar_id, axi_ar_len};
  assign w_pay_s  = {axi_w_data, axi_w_strb, axi_w_last};

  // An empty FIFO with a same-cycle address handshake uses the live address as reference.
  always_comb begin
    aw_head_valid_s = !aw_empty_s || aw_hs_s;
    aw_head_len_s   = aw_empty_s ? axi_aw_len : aw_dout_s;
    w_done_s  = w_hs_s && aw_head_valid_s && (axi_w_last || (wbeat_r == aw_head_len_s));
    aw_pop_s  = w_done_s && !aw_empty_s;
    aw_push_s = aw_hs_s && !(w_done_s && aw_empty_s);
    b_dec_s   = b_hs_s && ((b_pending_r != 16'd0) || w_done_s);

    ar_head_valid_s = !ar_empty_s || ar_hs_s;
    ar_head_id_s    = ar_empty_s ? axi_ar_id  : ar_dout_s[AR_FIFO_W-1:8];
    ar_head_len_s   = ar_empty_s ? axi_ar_len : ar_dout_s[7:0];
    r_done_s  = r_hs_s && ar_head_valid_s && (axi_r_last || (rbeat_r == ar_head_len_s));
    ar_pop_s  = r_done_s && !ar_empty_s;
    ar_push_s = ar_hs_s && !(r_done_s && ar_empty_s);
  end

  axi_monitor_track_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_aw_fifo (
    .clk(clk), .rst(rst), .push(aw_push_s), .pop(aw_pop_s), .din(axi_aw_len),
    .dout(aw_dout_s), .full(aw_full_s), .empty(aw_empty_s)
  );

  axi_monitor_track_fifo #(.WIDTH(AR_FIFO_W), .DEPTH(MAX_OUTSTANDING)) u_ar_fifo (
    .clk(clk), .rst(rst), .push(ar_push_s), .pop(ar_pop_s), .din({axi_ar_id, axi_ar_len}),
    .dout(ar_dout_s), .full(ar_full_s), .empty(ar_empty_s)
  );

  // Timeout fires on the cycle a channel's stall count reaches the limit, once per episode.
  always_comb begin
    timeout_s = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      timeout_s = timeout_s | (stalled_s[c] && (tmr_r[c] == TMR_W'(STALL_LIMIT - 1)));
    end
  end

  // Violation vector, one bit per code.
  always_comb begin
    viol_s = '0;
    viol_s[ERR_AW_UNSTABLE]    = aw_stall_r && (!axi_aw_valid || (aw_pay_s != aw_pay_r));
    viol_s[ERR_W_UNSTABLE]     = w_stall_r  && (!axi_w_valid  || (w_pay_s  != w_pay_r));
    viol_s[ERR_AR_UNSTABLE]    = ar_stall_r && (!axi_ar_valid || (ar_pay_s != ar_pay_r));
    viol_s[ERR_WLAST_EARLY]    = w_hs_s && aw_head_valid_s && axi_w_last && (wbeat_r < aw_head_len_s);
    viol_s[ERR_WLAST_MISSING]  = w_hs_s && aw_head_valid_s && !axi_w_last && (wbeat_r == aw_head_len_s);
    viol_s[ERR_B_UNEXPECTED]   = b_hs_s && (b_pending_r == 16'd0) && !w_done_s;
    viol_s[ERR_RLAST_EARLY]    = r_hs_s && ar_head_valid_s && axi_r_last && (rbeat_r < ar_head_len_s);
    viol_s[ERR_RLAST_MISSING]  = r_hs_s && ar_head_valid_s && !axi_r_last && (rbeat_r == ar_head_len_s);
    viol_s[ERR_RID_MISMATCH]   = r_hs_s && ar_head_valid_s && (axi_r_id != ar_head_id_s);
    viol_s[ERR_R_UNEXPECTED]   = r_hs_s && !ar_head_valid_s;
    viol_s[ERR_TRACK_OVERFLOW] = (aw_hs_s && aw_full_s && !aw_pop_s) || (ar_hs_s && ar_full_s && !ar_pop_s);
    viol_s[ERR_STALL_TIMEOUT]  = timeout_s;
    viol_s[ERR_W_NO_AW]        = w_hs_s && !aw_head_valid_s;
  end

  // Beat counters, write-response credit and stall snapshots.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbeat_r     <= 8'd0;
      rbeat_r     <= 8'd0;
      b_pending_r <= 16'd0;
      aw_stall_r  <= 1'b0;
      w_stall_r   <= 1'b0;
      ar_stall_r  <= 1'b0;
      aw_pay_r    <= '0;
      w_pay_r     <= '0;
      ar_pay_r    <= '0;
    end else begin
      if (w_hs_s && aw_head_valid_s) wbeat_r <= w_done_s ? 8'd0 : wbeat_r + 8'd1;
      if (r_hs_s && ar_head_valid_s) rbeat_r <= r_done_s ? 8'd0 : rbeat_r + 8'd1;
      b_pending_r <= b_pending_r + {15'd0, w_done_s} - {15'd0, b_dec_s};
      aw_stall_r  <= stalled_s[0];
      w_stall_r   <= stalled_s[1];
      ar_stall_r  <= stalled_s[3];
      aw_pay_r    <= aw_pay_s;
      w_pay_r     <= w_pay_s;
      ar_pay_r    <= ar_pay_s;
    end
  end

  // Per-channel stall timers, saturating at the limit until the stall ends.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst || !stalled_s[c]) tmr_r[c] <= '0;
      else if (tmr_r[c] != TMR_W'(STALL_LIMIT)) tmr_r[c] <= tmr_r[c] + TMR_W'(1);
      else tmr_r[c] <= tmr_r[c];
    end
  end

  // Error reporting and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid_r <= 1'b0;
      err_code_r  <= 4'd0;
      err_flags_r <= 16'd0;
      wr_cnt_r    <= 32'd0;
      rd_cnt_r    <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      err_valid_r <= |viol_s;
      err_code_r  <= first_err(viol_s);
      err_flags_r <= err_flags_r | viol_s;
      if (b_hs_s) wr_cnt_r <= wr_cnt_r + 32'd1;
      if (r_hs_s && axi_r_last) rd_cnt_r <= rd_cnt_r + 32'd1;
      if (|stalled_s) stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign err_valid    = err_valid_r;
  assign err_code     = err_code_r;
  assign err_flags    = err_flags_r;
  assign wr_burst_cnt = wr_cnt_r;
  assign rd_burst_cnt = rd_cnt_r;
  assign stall_cnt    = stall_cnt_r;
  assign busy         = !aw_empty_s || !ar_empty_s || (b_pending_r != 16'd0);

endmodule

// File: tb/tb_axi_protocol_monitor.sv
// Directed bench for axi_protocol_monitor: a per-cycle vector table followed
// by hand-written multi-cycle sequences for stalls, overflow and reset.
module tb_axi_protocol_monitor;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] axi_aw_addr, axi_ar_addr, axi_w_data, axi_r_data;
  logic [1:0]  axi_aw_burst, axi_ar_burst, axi_b_resp, axi_r_resp;
  logic [2:0]  axi_aw_size, axi_ar_size;
  logic [7:0]  axi_aw_id, axi_aw_len, axi_b_id, axi_ar_id, axi_ar_len, axi_r_id;
  logic [3:0]  axi_w_strb;
  logic axi_aw_valid, axi_aw_ready, axi_w_last, axi_w_valid, axi_w_ready;
  logic axi_b_valid, axi_b_ready, axi_ar_valid, axi_ar_ready;
  logic axi_r_last, axi_r_valid, axi_r_ready;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [15:0] err_flags;
  logic [31:0] wr_burst_cnt, rd_burst_cnt, stall_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_protocol_monitor dut (
    .clk(clk), .rst(rst),
    .axi_aw_addr(axi_aw_addr), .axi_aw_burst(axi_aw_burst), .axi_aw_size(axi_aw_size),
    .axi_aw_id(axi_aw_id), .axi_aw_len(axi_aw_len), .axi_aw_valid(axi_aw_valid),
    .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid),
    .axi_b_ready(axi_b_ready),
    .axi_ar_addr(axi_ar_addr), .axi_ar_burst(axi_ar_burst), .axi_ar_size(axi_ar_size),
    .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_valid(axi_ar_valid),
    .axi_ar_ready(axi_ar_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
    .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .err_valid(err_valid), .err_code(err_code), .err_flags(err_flags),
    .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt), .stall_cnt(stall_cnt),
    .busy(busy)
  );

  // vr = {aw_v, aw_r, w_v, w_r, b_v, b_r, ar_v, ar_r, r_v, r_r}
  typedef struct {
    string      name;
    logic [9:0] vr;
    logic [7:0] aw_len;
    logic       w_last;
    logic [7:0] ar_id;
    logic [7:0] ar_len;
    logic [7:0] r_id;
    logic       r_last;
    logic       exp_ev;
    logic [3:0] exp_code;
    logic       exp_busy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string name, input logic [9:0] vr, input logic [7:0] aw_len,
                              input logic w_last, input logic [7:0] ar_id, input logic [7:0] ar_len,
                              input logic [7:0] r_id, input logic r_last, input logic exp_ev,
                              input logic [3:0] exp_code, input logic exp_busy);
    vec_t v;
    v.name = name; v.vr = vr; v.aw_len = aw_len; v.w_last = w_last;
    v.ar_id = ar_id; v.ar_len = ar_len; v.r_id = r_id; v.r_last = r_last;
    v.exp_ev = exp_ev; v.exp_code = exp_code; v.exp_busy = exp_busy;
    vq.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_ready, axi_b_valid, axi_b_ready,
     axi_ar_valid, axi_ar_ready, axi_r_valid, axi_r_ready} = 10'd0;
    axi_w_last = 1'b0;
    axi_r_last = 1'b0;
  endtask

  task automatic set_vr(input logic [9:0] vr);
    {axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_ready, axi_b_valid, axi_b_ready,
     axi_ar_valid, axi_ar_ready, axi_r_valid, axi_r_ready} = vr;
  endtask

  task automatic apply(input vec_t v);
    set_vr(v.vr);
    axi_aw_len = v.aw_len; axi_w_last = v.w_last;
    axi_ar_id = v.ar_id; axi_ar_len = v.ar_len;
    axi_r_id = v.r_id; axi_r_last = v.r_last;
    step();
    check({v.name, ".err_valid"}, {31'd0, err_valid}, {31'd0, v.exp_ev});
    check({v.name, ".err_code"}, {28'd0, err_code}, {28'd0, v.exp_code});
    check({v.name, ".busy"}, {31'd0, busy}, {31'd0, v.exp_busy});
  endtask

  int pulses;
  int pulse_at;
  logic [3:0] pulse_code;

  initial begin
    rst = 1'b1;
    axi_aw_addr = 32'h100; axi_aw_burst = 2'b01; axi_aw_size = 3'd2; axi_aw_id = 8'd0; axi_aw_len = 8'd0;
    axi_ar_addr = 32'h200; axi_ar_burst = 2'b01; axi_ar_size = 3'd2; axi_ar_id = 8'd0; axi_ar_len = 8'd0;
    axi_w_data = 32'hA5A5_0000; axi_w_strb = 4'hF; axi_b_id = 8'd0; axi_b_resp = 2'b00;
    axi_r_id = 8'd0; axi_r_data = 32'd0; axi_r_resp = 2'b00;
    idle();
    repeat (3) step();
    check("rst.err_valid", {31'd0, err_valid}, 32'd0);
    check("rst.err_code", {28'd0, err_code}, 32'd0);
    check("rst.err_flags", {16'd0, err_flags}, 32'd0);
    check("rst.wr_cnt", wr_burst_cnt, 32'd0);
    check("rst.stall_cnt", stall_cnt, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    //   name        vr                 awlen wl  arid arlen rid rl  ev code busy
    add("wr_aw",     10'b11_00_00_00_00, 8'd3, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("wr_w0",     10'b00_11_00_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("wr_w1",     10'b00_11_00_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("wr_w2",     10'b00_11_00_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("wr_w3",     10'b00_11_00_00_00, 8'd0, 1, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("wr_b",      10'b00_00_11_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 0);
    add("early_aw",  10'b11_00_00_00_00, 8'd3, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("early_w0",  10'b00_11_00_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("early_w1",  10'b00_11_00_00_00, 8'd0, 1, 8'd0, 8'd0, 8'd0, 0, 1, 4'd4, 1);
    add("early_b",   10'b00_00_11_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 0);
    add("good_aw",   10'b11_00_00_00_00, 8'd1, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("good_w0",   10'b00_11_00_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("good_w1",   10'b00_11_00_00_00, 8'd0, 1, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("good_b",    10'b00_00_11_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 0);
    add("rid_ar",    10'b00_00_00_11_00, 8'd0, 0, 8'd5, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("rid_r",     10'b00_00_00_00_11, 8'd0, 0, 8'd0, 8'd0, 8'd6, 1, 1, 4'd9, 0);
    add("lone_r",    10'b00_00_00_00_11, 8'd0, 0, 8'd0, 8'd0, 8'd0, 1, 1, 4'd10, 0);
    add("ar_bypass", 10'b00_00_00_11_11, 8'd0, 0, 8'd3, 8'd0, 8'd3, 1, 0, 4'd0, 0);
    add("aw_bypass", 10'b11_11_00_00_00, 8'd0, 1, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("byp_b",     10'b00_00_11_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 0);
    add("wb_aw",     10'b11_00_00_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("wb_same",   10'b00_11_11_00_00, 8'd0, 1, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 0);
    add("miss_aw",   10'b11_00_00_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("miss_w",    10'b00_11_00_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 1, 4'd5, 1);
    add("miss_b",    10'b00_00_11_00_00, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 4'd0, 0);
    add("w_no_aw",   10'b00_11_00_00_00, 8'd0, 1, 8'd0, 8'd0, 8'd0, 0, 1, 4'd13, 0);
    add("rearly_ar", 10'b00_00_00_11_00, 8'd0, 0, 8'd1, 8'd2, 8'd0, 0, 0, 4'd0, 1);
    add("rearly_r",  10'b00_00_00_00_11, 8'd0, 0, 8'd0, 8'd0, 8'd1, 1, 1, 4'd7, 0);
    add("rmiss_ar",  10'b00_00_00_11_00, 8'd0, 0, 8'd2, 8'd0, 8'd0, 0, 0, 4'd0, 1);
    add("rmiss_r",   10'b00_00_00_00_11, 8'd0, 0, 8'd0, 8'd0, 8'd2, 0, 1, 4'd8, 0);
    add("multi_ar",  10'b00_00_00_11_00, 8'd0, 0, 8'd1, 8'd1, 8'd0, 0, 0, 4'd0, 1);
    add("multi_r",   10'b00_00_00_00_11, 8'd0, 0, 8'd0, 8'd0, 8'd7, 1, 1, 4'd7, 0);

    for (int i = 0; i < vq.size(); i++) apply(vq[i]);
    idle();
    check("tbl.err_flags", {16'd0, err_flags}, 32'h0000_27B0);
    check("tbl.wr_cnt", wr_burst_cnt, 32'd6);
    check("tbl.rd_cnt", rd_burst_cnt, 32'd5);
    check("tbl.stall_cnt", stall_cnt, 32'd0);

    // AW payload changes while stalled
    axi_aw_len = 8'd0; axi_aw_addr = 32'h100; set_vr(10'b10_00_00_00_00); step();
    check("stab.first", {31'd0, err_valid}, 32'd0);
    axi_aw_addr = 32'h104; step();
    check("stab.ev", {31'd0, err_valid}, 32'd1);
    check("stab.code", {28'd0, err_code}, 32'd1);
    set_vr(10'b11_00_00_00_00); step();
    check("stab.accept", {31'd0, err_valid}, 32'd0);
    axi_w_last = 1'b1; set_vr(10'b00_11_00_00_00); step();
    set_vr(10'b00_00_11_00_00); step();
    check("stab.busy", {31'd0, busy}, 32'd0);

    // Five AWs into a four-deep tracker, then push+pop while full
    idle(); axi_aw_len = 8'd0; set_vr(10'b11_00_00_00_00);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("ovf.ev%0d", i), {31'd0, err_valid}, (i == 5) ? 32'd1 : 32'd0);
    end
    check("ovf.code", {28'd0, err_code}, 32'd11);
    axi_w_last = 1'b1; set_vr(10'b11_11_00_00_00); step();
    check("ovf.pushpop", {31'd0, err_valid}, 32'd0);
    set_vr(10'b00_11_00_00_00); repeat (4) step();
    set_vr(10'b00_00_11_00_00); repeat (5) step();
    check("ovf.drain_ev", {31'd0, err_valid}, 32'd0);
    check("ovf.busy", {31'd0, busy}, 32'd0);

    // AR stalled for STALL_LIMIT cycles
    idle(); axi_ar_id = 8'd0; axi_ar_len = 8'd0; set_vr(10'b00_00_00_10_00);
    pulses = 0; pulse_at = 0; pulse_code = 4'd0;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (err_valid) begin
        pulses++; pulse_at = i; pulse_code = err_code;
      end
    end
    check("stall.pulses", pulses, 32'd1);
    check("stall.at", pulse_at, 32'd256);
    check("stall.code", {28'd0, pulse_code}, 32'd12);
    check("stall.cnt", stall_cnt, 32'd258);
    set_vr(10'b00_00_00_11_00); step();
    check("stall.release", {31'd0, err_valid}, 32'd0);
    axi_r_id = 8'd0; axi_r_last = 1'b1; set_vr(10'b00_00_00_00_11); step();
    check("stall.rdone", {31'd0, err_valid}, 32'd0);

    // Unexpected B in the same cycle as an AR overflow
    idle(); set_vr(10'b00_00_00_11_00); repeat (4) step();
    check("bov.fill", {31'd0, err_valid}, 32'd0);
    set_vr(10'b00_00_11_11_00); step();
    check("bov.ev", {31'd0, err_valid}, 32'd1);
    check("bov.code", {28'd0, err_code}, 32'd6);
    check("bov.flag6", {31'd0, err_flags[6]}, 32'd1);
    check("bov.flag11", {31'd0, err_flags[11]}, 32'd1);
    axi_r_last = 1'b1; set_vr(10'b00_00_00_00_11); repeat (4) step();
    check("bov.drain", {31'd0, busy}, 32'd0);
    check("end.wr_cnt", wr_burst_cnt, 32'd13);
    check("end.rd_cnt", rd_burst_cnt, 32'd10);

    // Reset in the middle of a write burst
    idle(); axi_aw_len = 8'd3; set_vr(10'b11_00_00_00_00); step();
    axi_w_last = 1'b0; set_vr(10'b00_11_00_00_00); step();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    check("mrst.busy", {31'd0, busy}, 32'd0);
    check("mrst.flags", {16'd0, err_flags}, 32'd0);
    check("mrst.wr_cnt", wr_burst_cnt, 32'd0);
    check("mrst.stall_cnt", stall_cnt, 32'd0);
    axi_aw_len = 8'd0; set_vr(10'b11_00_00_00_00); step();
    axi_w_last = 1'b1; set_vr(10'b00_11_00_00_00); step();
    check("mrst.w_ev", {31'd0, err_valid}, 32'd0);
    set_vr(10'b00_00_11_00_00); step();
    check("mrst.b_ev", {31'd0, err_valid}, 32'd0);
    check("mrst.wr_cnt1", wr_burst_cnt, 32'd1);
    check("mrst.busy_end", {31'd0, busy}, 32'd0);
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
